// File: rtl/apb_pkg.sv
// Shared APB definitions used by the masters and by this completer.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } apb_state;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 8;
  localparam logic [APB_ADDR_W-1:0] ADDER_BASE_ADDR = 32'hD0AD00;

endpackage

// File: rtl/apb_regfile.sv
// Byte-wide register file: writable registers 0..NUM_REGS-2 plus a constant
// read-only ID register at the top index.
module apb_regfile
  import apb_pkg::*;
#(
  parameter int                    NUM_REGS = 8,
  parameter logic [APB_DATA_W-1:0] ID_VALUE = 8'hA5,
  parameter int                    IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  we,
  input  logic [IDX_W-1:0]      idx,
  input  logic [APB_DATA_W-1:0] wdata,
  output logic [APB_DATA_W-1:0] rdata
);

  logic [APB_DATA_W-1:0] mem [NUM_REGS-1];

  // NOTE: the array is small and software expects zeros after reset, so every
  // entry is reset; a large RAM-style array would be left unreset instead.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int i = 0; i < NUM_REGS - 1; i++) mem[i] <= '0;
    end else if (we) begin
      // The ID index never matches here, so writes to it are dropped.
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        if (idx == IDX_W'(i)) mem[i] <= wdata;
      end
    end
  end

  // NOTE: rdata gets a default before the loop so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    rdata = ID_VALUE;
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      if (idx == IDX_W'(i)) rdata = mem[i];
    end
  end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB3 completer for a small byte-wide register file with programmable wait
// states and PSLVERR on out-of-range or read-only accesses.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = ADDER_BASE_ADDR,
  parameter int                    NUM_REGS    = 8,
  parameter int                    WAIT_CYCLES = 0,
  parameter logic [APB_DATA_W-1:0] ID_VALUE    = 8'hA5
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic [APB_ADDR_W-1:0] paddr_i,
  input  logic                  pwrite_i,
  input  logic [APB_DATA_W-1:0] pwdata_i,
  output logic                  pready_o,
  output logic [APB_DATA_W-1:0] prdata_o,
  output logic                  pslverr_o
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int CNT_W = 4;

  apb_state state, state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [APB_ADDR_W-1:0] cap_addr;
  logic                  cap_write;
  logic [APB_DATA_W-1:0] cap_wdata;

  logic                  setup, done, hit, ro_hit, rf_we;
  logic [APB_ADDR_W-1:0] offset;
  logic [IDX_W-1:0]      idx;
  logic [APB_DATA_W-1:0] rf_rdata;

  assign setup = (state == ST_IDLE) && psel_i && !penable_i;
  assign done  = (state == ST_ACCESS) && psel_i && penable_i && (cnt == '0);

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (setup) state_nxt = ST_ACCESS;
      ST_ACCESS: if (!psel_i || done) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Captured request and wait counter; pwdata_i is only looked at during setup.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      cnt       <= '0;
      cap_addr  <= '0;
      cap_write <= 1'b0;
      cap_wdata <= '0;
    end else if (setup) begin
      cnt       <= CNT_W'(WAIT_CYCLES);
      cap_addr  <= paddr_i;
      cap_write <= pwrite_i;
      cap_wdata <= pwdata_i;
    end else if ((state == ST_ACCESS) && psel_i && penable_i && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Subtraction wraps for addresses below the base, hence the explicit >= test.
  assign offset = cap_addr - BASE_ADDR;
  assign hit    = (cap_addr >= BASE_ADDR) && (offset < APB_ADDR_W'(NUM_REGS));
  assign idx    = offset[IDX_W-1:0];
  assign ro_hit = hit && (idx == IDX_W'(NUM_REGS - 1));

  always_comb begin
    pready_o  = done;
    pslverr_o = done && (!hit || (cap_write && ro_hit));
    prdata_o  = (done && !cap_write && hit) ? rf_rdata : '0;
    rf_we     = done && cap_write && hit;
  end

  apb_regfile #(
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .pclk   (pclk),
    .preset (preset),
    .we     (rf_we),
    .idx    (idx),
    .wdata  (cap_wdata),
    .rdata  (rf_rdata)
  );

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: a zero-wait and a three-wait instance on
// separate selects, checked against an address-map model of the register file.
module tb_apb_slave_regfile;

  localparam logic [31:0] BASE = 32'hD0AD00;
  localparam int          NREG = 8;
  localparam logic [7:0]  IDV  = 8'hA5;
  localparam int          WAITS [2] = '{0, 3};

  logic             pclk = 1'b0;
  logic             preset;
  logic [1:0]       psel;
  logic             penable, pwrite;
  logic [31:0]      paddr;
  logic [7:0]       pwdata;
  logic [1:0]       pready, pslverr;
  logic [1:0][7:0]  prdata;

  int errors = 0;
  int checks = 0;

  logic [7:0] mdl [2][NREG];

  always #5 pclk = ~pclk;

  apb_slave_regfile #(.WAIT_CYCLES(0)) dut0 (
    .pclk(pclk), .preset(preset), .psel_i(psel[0]), .penable_i(penable),
    .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata),
    .pready_o(pready[0]), .prdata_o(prdata[0]), .pslverr_o(pslverr[0])
  );

  apb_slave_regfile #(.WAIT_CYCLES(3)) dut3 (
    .pclk(pclk), .preset(preset), .psel_i(psel[1]), .penable_i(penable),
    .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata),
    .pready_o(pready[1]), .prdata_o(prdata[1]), .pslverr_o(pslverr[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NREG; i++) mdl[d][i] = 8'h00;
  endtask

  // Address-map view: in range is BASE..BASE+NREG-1, top byte is the constant ID.
  task automatic mdl_access(input int d, input logic wr, input logic [31:0] addr,
                            input logic [7:0] data, output logic [7:0] rd, output logic err);
    longint off;
    off = longint'(addr) - longint'(BASE);
    rd  = 8'h00;
    err = 1'b0;
    if (off < 0 || off >= NREG) err = 1'b1;
    else if (wr) begin
      if (off == NREG - 1) err = 1'b1;
      else mdl[d][off] = data;
    end else begin
      rd = (off == NREG - 1) ? IDV : mdl[d][off];
    end
  endtask

  task automatic idle();
    @(posedge pclk); #1;
    psel = '0; penable = 1'b0;
  endtask

  // One APB transfer on instance d; returns at the negedge where pready is seen.
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr, input logic [7:0] data,
                      output logic [7:0] rd, output logic err, output int lat);
    @(posedge pclk); #1;
    psel = '0; psel[d] = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = data;
    @(posedge pclk); #1;
    penable = 1'b1;
    pwdata = ~data;
    lat = 0; rd = '0; err = 1'b0;
    forever begin
      @(negedge pclk);
      lat++;
      if (pready[d]) begin
        rd  = prdata[d];
        err = pslverr[d];
        break;
      end
      if (lat >= 40) begin
        errors++; checks++;
        $display("FAIL timeout: no pready on dut%0d after %0d cycles", d, lat);
        break;
      end
      @(posedge pclk); #1;
    end
  endtask

  task automatic run(input int d, input logic wr, input logic [31:0] addr, input logic [7:0] data,
                     input string name, output logic [7:0] rd);
    logic [7:0] exp_rd;
    logic       exp_err, err;
    int         lat;
    mdl_access(d, wr, addr, data, exp_rd, exp_err);
    xfer(d, wr, addr, data, rd, err, lat);
    check({name, " rdata"}, 32'(rd), 32'(exp_rd));
    check({name, " err"}, 32'(err), 32'(exp_err));
    check({name, " latency"}, lat, WAITS[d] + 1);
  endtask

  typedef struct {
    string       name;
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rd;
    logic        exp_err;
  } vec_t;

  initial begin
    vec_t       tbl [7];
    logic [7:0] rd, mrd;
    logic       err, merr;
    int         lat;

    tbl[0] = '{"wr 3C @02",       1'b1, 32'hD0AD02, 8'h3C, 8'h00, 1'b0};
    tbl[1] = '{"rd @02",          1'b0, 32'hD0AD02, 8'h00, 8'h3C, 1'b0};
    tbl[2] = '{"rd miss @08",     1'b0, 32'hD0AD08, 8'h00, 8'h00, 1'b1};
    tbl[3] = '{"wr miss @ACFF",   1'b1, 32'hD0ACFF, 8'h99, 8'h00, 1'b1};
    tbl[4] = '{"wr ro @07",       1'b1, 32'hD0AD07, 8'hFF, 8'h00, 1'b1};
    tbl[5] = '{"rd id @07",       1'b0, 32'hD0AD07, 8'h00, 8'hA5, 1'b0};
    tbl[6] = '{"rd @02 after err",1'b0, 32'hD0AD02, 8'h00, 8'h3C, 1'b0};

    preset = 1'b1; psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    mdl_reset();
    #3;
    check("reset pready", 32'(pready), 32'h0);
    check("reset prdata", 32'(prdata), 32'h0);
    check("reset pslverr", 32'(pslverr), 32'h0);
    repeat (2) @(posedge pclk);
    #1 preset = 1'b0;

    // Zero-wait vectors, including miss / read-only / ID cases.
    for (int i = 0; i < 7; i++) begin
      mdl_access(0, tbl[i].wr, tbl[i].addr, tbl[i].wdata, mrd, merr);
      xfer(0, tbl[i].wr, tbl[i].addr, tbl[i].wdata, rd, err, lat);
      check({tbl[i].name, " rdata"}, 32'(rd), 32'(tbl[i].exp_rd));
      check({tbl[i].name, " err"}, 32'(err), 32'(tbl[i].exp_err));
      check({tbl[i].name, " latency"}, lat, 1);
    end
    idle();

    // Three wait states: ready only on the fourth access cycle.
    run(1, 1'b0, 32'hD0AD00, 8'h00, "w3 rd @00", rd);
    idle();

    // Read-modify-write increment, 256 passes wraps back to zero.
    for (int i = 0; i < 256; i++) begin
      run(0, 1'b0, 32'hD0AD00, 8'h00, "rmw rd", rd);
      run(0, 1'b1, 32'hD0AD00, rd + 8'h01, "rmw wr", mrd);
    end
    run(0, 1'b0, 32'hD0AD00, 8'h00, "rmw final", rd);
    check("rmw wrapped", 32'(rd), 32'h00);
    idle();

    // Abort: drop psel mid-wait during a write.
    @(posedge pclk); #1;
    psel = 2'b10; penable = 1'b0; pwrite = 1'b1; paddr = 32'hD0AD01; pwdata = 8'h55;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    check("abort wait pready", 32'(pready[1]), 32'h0);
    @(posedge pclk); #1;
    psel = '0; penable = 1'b0;
    @(negedge pclk);
    check("abort pready", 32'(pready[1]), 32'h0);
    run(1, 1'b0, 32'hD0AD01, 8'h00, "abort rd @01", rd);
    check("abort reg kept", 32'(rd), 32'h00);
    idle();

    // Reset in the middle of a write access.
    run(1, 1'b1, 32'hD0AD03, 8'h66, "pre-rst wr", rd);
    @(posedge pclk); #1;
    psel = 2'b10; penable = 1'b0; pwrite = 1'b1; paddr = 32'hD0AD05; pwdata = 8'h77;
    @(posedge pclk); #1;
    penable = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    check("rst: ready before", 32'(pready[1]), 32'h1);
    #2 preset = 1'b1;
    #1;
    check("rst pready", 32'(pready), 32'h0);
    check("rst pslverr", 32'(pslverr), 32'h0);
    check("rst prdata", 32'(prdata), 32'h0);
    mdl_reset();
    @(posedge pclk); #1;
    preset = 1'b0; psel = '0; penable = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      run(1, 1'b0, BASE + 32'(i), 8'h00, $sformatf("post-rst rd %0d", i), rd);
    end
    idle();

    // Stray penable while idle, then back-to-back writes.
    @(posedge pclk); #1;
    psel = 2'b01; penable = 1'b1; pwrite = 1'b1; paddr = 32'hD0AD03; pwdata = 8'hEE;
    @(negedge pclk);
    check("stray pready", 32'(pready[0]), 32'h0);
    @(negedge pclk);
    check("stray pready 2", 32'(pready[0]), 32'h0);
    run(0, 1'b1, 32'hD0AD03, 8'h11, "b2b wr 03", rd);
    run(0, 1'b1, 32'hD0AD04, 8'h22, "b2b wr 04", rd);
    run(0, 1'b0, 32'hD0AD03, 8'h00, "b2b rd 03", rd);
    check("b2b 03 value", 32'(rd), 32'h11);
    run(0, 1'b0, 32'hD0AD04, 8'h00, "b2b rd 04", rd);
    check("b2b 04 value", 32'(rd), 32'h22);
    idle();

    // Random traffic around the mapped window on both instances.
    for (int i = 0; i < 200; i++) begin
      int          d;
      logic        wr;
      logic [31:0] addr;
      d    = int'($urandom_range(0, 1));
      wr   = 1'($urandom_range(0, 1));
      addr = BASE - 32'd2 + 32'($urandom_range(0, 12));
      run(d, wr, addr, 8'($urandom), $sformatf("rand %0d", i), rd);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
APB3 completer: the target end of the APB read/modify/write path driven by the team's APB masters.
Holds a small byte-wide register file mapped at BASE_ADDR (32'hD0AD00).
Supports programmable wait-state insertion and raises PSLVERR on out-of-range or read-only-violating accesses.
Sits on the APB bus as the responder for address 32'hD0AD00 and its neighbours.

Parameters:
BASE_ADDR, 32'hD0AD00, byte address of register 0
NUM_REGS, 8, number of 8-bit registers; byte offsets 0..NUM_REGS-1
WAIT_CYCLES, 0, access-phase cycles with pready low before completion (0..15)
ID_VALUE, 8'hA5, constant returned by the top register (index NUM_REGS-1), which is read-only

Ports:
pclk  input  1  APB clock, all state on rising edge
preset  input  1  asynchronous, active-high reset
psel_i  input  1  slave select
penable_i  input  1  access phase indicator
paddr_i  input  32  byte address
pwrite_i  input  1  1 = write, 0 = read
pwdata_i  input  8  write data
pready_o  output  1  transfer completion
prdata_o  output  8  read data, valid only when pready_o=1 on a read
pslverr_o  output  1  error response, valid only when pready_o=1

Behaviour:
- Reset (preset=1, async): state=ST_IDLE, wait counter=0, registers 0..NUM_REGS-2 = 8'h00, captured addr/write/wdata cleared. pready_o=0, prdata_o=8'h00, pslverr_o=0.
- States: ST_IDLE, ST_ACCESS.
- ST_IDLE:
  - On psel_i=1 and penable_i=0 (setup phase): capture paddr_i, pwrite_i and pwdata_i; load counter with WAIT_CYCLES; go to ST_ACCESS.
  - penable_i=1 while in ST_IDLE (no prior setup) is ignored; pready_o stays 0.
- ST_ACCESS, while psel_i=1 and penable_i=1:
  - If counter != 0: decrement; pready_o=0.
  - If counter == 0: pready_o=1 this cycle; at the edge, commit the transfer and return to ST_IDLE.
- Abort: psel_i=0 in ST_ACCESS returns to ST_IDLE with no register update and pready_o=0.
- Latency: completion lands on the (WAIT_CYCLES+1)-th access-phase cycle. With WAIT_CYCLES=0, pready_o=1 in the first penable cycle.
- Outputs pready_o, prdata_o and pslverr_o are combinational from state, counter, captured fields and the register file.
- Decode:
  - offset = captured_addr - BASE_ADDR (32-bit unsigned).
  - Hit if captured_addr >= BASE_ADDR and offset < NUM_REGS; the index is offset[$clog2(NUM_REGS)-1:0].
- Error rules, evaluated at completion (pslverr_o=1 only while pready_o=1):
  - Miss (read or write): pslverr_o=1, no update, prdata_o=8'h00.
  - Write to index NUM_REGS-1: pslverr_o=1, no update.
  - Reads of index NUM_REGS-1 return ID_VALUE with pslverr_o=0.
- Write commit: reg[index] <= captured pwdata at the completion edge. pwdata_i is sampled at setup; later changes are ignored.
- Read: prdata_o = reg[index] while pready_o=1 and read; 8'h00 otherwise.
- Back-to-back: a setup phase in the cycle immediately after completion is accepted with no idle gap.
- Reset mid-transfer: the transfer is dropped, no write occurs, and all outputs return to reset values immediately.

Decomposition:
- Package apb_pkg holds:
  - apb_state enum (ST_IDLE, ST_SETUP, ST_ACCESS), shared with the masters; this slave uses ST_IDLE and ST_ACCESS only.
  - APB_ADDR_W=32 and APB_DATA_W=8.
  - ADDER_BASE_ADDR=32'hD0AD00.
- One sub-module, apb_regfile, contains the NUM_REGS x 8 storage, the read mux, the read-only ID register and write enable gating.
- The APB FSM, wait counter and decode/error logic stay in apb_slave_regfile.

Test Plan:
1. WAIT_CYCLES=0: write 8'h3C to 32'hD0AD02, then read 32'hD0AD02 -> write completes in 1st penable cycle with pslverr_o=0; read returns prdata_o=8'h3C in 1st penable cycle.
2. WAIT_CYCLES=3: read 32'hD0AD00 after reset -> pready_o low for 3 access cycles, high on the 4th, prdata_o=8'h00, pslverr_o=0.
3. Read-modify-write: read 32'hD0AD00 (8'h00), write 8'h01, read back -> 8'h01. Repeat 256 times -> value wraps back to 8'h00.
4. Error cases:
   - Read 32'hD0AD08 -> pslverr_o=1, prdata_o=8'h00.
   - Write 32'hD0ACFF -> pslverr_o=1, no register changes.
   - Write 8'hFF to 32'hD0AD07 -> pslverr_o=1; a subsequent read returns 8'hA5.
5. Abort and reset:
   - Deassert psel_i mid-wait (WAIT_CYCLES=3) during a write of 8'h55 to 32'hD0AD01 -> the register stays 8'h00.
   - Assert preset mid-access -> pready_o drops immediately and all registers read 8'h00 afterwards.
6. Back-to-back writes to 32'hD0AD03 (8'h11) then 32'hD0AD04 (8'h22) with no idle cycle, plus a stray penable_i=1 without setup while idle -> both writes land; the stray cycle gets no pready_o.
